// File: rtl/sync_arb_pkg.sv
// rtl/sync_arb_pkg.sv - shared types and defaults for the synchronizing request arbiter
// Contents: arbiter FSM state enum, default requester count, default grant timeout.
package sync_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/sync_chan.sv
// rtl/sync_chan.sv - one-bit 2-flop synchronizer with edge-history flop and rise detect
// Ports:
//   clk      system clock
//   n_rst    synchronous active-low reset
//   async_in asynchronous level input
//   rise     one-cycle pulse when the synchronized level goes 0 -> 1
module sync_chan (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic rise
);

  logic       meta_q;
  logic       sync_q;
  logic       hist_q;
  logic [2:0] vld_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
      vld_q  <= 3'b000;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      hist_q <= sync_q;
      vld_q  <= {vld_q[1:0], 1'b1};
    end
  end

  // vld_q tracks when hist_q holds a real post-reset sample. The first
  // synchronized sample after reset is only a baseline, so a requester held
  // high through reset does not look like a fresh 0 -> 1 transition.
  assign rise = sync_q & ~hist_q & vld_q[2];

endmodule

// File: rtl/sync_req_arbiter.sv
// rtl/sync_req_arbiter.sv - round-robin arbiter for asynchronous level requests
// Optional feature macro: ARB_TIMEOUT_EN (grant abort after TIMEOUT_CYCLES grant cycles).
// Ports:
//   clk          system clock
//   n_rst        synchronous active-low reset
//   async_req    asynchronous level requests, one per requester
//   done         granted requester has finished
//   grant        registered one-hot grant
//   grant_valid  high while any grant bit is high
//   grant_id     index of the granted requester, holds last value when idle
//   timeout      one-cycle pulse on grant abort (ARB_TIMEOUT_EN only)
module sync_req_arbiter
  import sync_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sync_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] pend_q, pend_d, clr;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     last_q, last_d;
  arb_state_t         state_q, state_d;

  logic               sel_found;
  logic [IDW-1:0]     sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    sync_chan u_chan (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (async_req[g]),
      .rise     (rise[g])
    );
  end

  // Round-robin pick: first pending index above the last grant, else the
  // first pending index at or below it (wrap-around).
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!sel_found && pend_q[j] && (j > int'(last_q))) begin
        sel_found     = 1'b1;
        sel_idx       = IDW'(j);
        sel_onehot[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!sel_found && pend_q[j] && (j <= int'(last_q))) begin
        sel_found     = 1'b1;
        sel_idx       = IDW'(j);
        sel_onehot[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    clr     = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      // RELEASE is the one grant-free cycle after a grant; its exit edge makes
      // the same decision IDLE would, so back-to-back grants are one cycle apart.
      ST_IDLE, ST_RELEASE: begin
        state_d = ST_IDLE;
        if (sel_found) begin
          grant_d = sel_onehot;
          clr     = sel_onehot;
          id_d    = sel_idx;
          last_d  = sel_idx;
          state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (done) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A rise on the issue edge re-queues the channel: set beats clear.
  assign pend_d = (pend_q & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      pend_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif

endmodule
